// File: rtl/pin_pkg.sv
// Shared definitions for command-bus slaves: opcodes, address fields, pin FSM states.
package pin_pkg;

   localparam int CTRL_H = 15;
   localparam int CTRL_L = 8;
   localparam int CMD_H  = 3;
   localparam int CMD_L  = 0;

   typedef enum logic [3:0] {
      CMD_CONST_LOW  = 4'd0,
      CMD_CONST_HIGH = 4'd1,
      CMD_SET_HIGH   = 4'd2,
      CMD_SET_LOW    = 4'd3,
      CMD_START      = 4'd4,
      CMD_STOP       = 4'd5,
      CMD_READ_COUNT = 4'd7
   } cmd_e;

   typedef enum logic [1:0] {
      ST_LOW   = 2'd0,
      ST_HIGH  = 2'd1,
      ST_SQ_HI = 2'd2,
      ST_SQ_LO = 2'd3
   } state_e;

   // A programmed phase length of zero behaves as one cycle.
   function automatic logic [15:0] eff_time(input logic [15:0] t);
      return (t == 16'd0) ? 16'd1 : t;
   endfunction

endpackage

// File: rtl/pin_controller_if.sv
// Scheduler command bus as seen by one pin slave, including the readback path.
interface pin_controller_if;
   logic [18:0] cmd_bus_addr;
   logic [15:0] cmd_bus_data;
   logic        cmd_bus_en;
   logic        cmd_bus_rd;
   logic        cmd_bus_wr;
   logic [15:0] rd_data;
   logic        rd_valid;

   modport master (output cmd_bus_addr, cmd_bus_data, cmd_bus_en, cmd_bus_rd, cmd_bus_wr,
                   input  rd_data, rd_valid);
   modport slave  (input  cmd_bus_addr, cmd_bus_data, cmd_bus_en, cmd_bus_rd, cmd_bus_wr,
                   output rd_data, rd_valid);
endinterface

// File: rtl/pin_controller_cmd_decode.sv
// Address match and write/read strobe decode for a command-bus slave at POSITION.
module cmd_decode
   import pin_pkg::*;
#(
   parameter logic [7:0] POSITION = 8'd0
) (
   input  logic [18:0] addr,
   input  logic        en,
   input  logic        wr,
   input  logic        rd,
   output logic        wr_acc,
   output logic        rd_acc,
   output logic [3:0]  cmd
);

   logic match;
   logic unused_addr_bits;

   assign match  = (addr[CTRL_H:CTRL_L] == POSITION);
   assign cmd    = addr[CMD_H:CMD_L];
   assign wr_acc = en & wr & match;
   // A simultaneous write wins; the read is dropped.
   assign rd_acc = en & rd & ~wr & match & (cmd == CMD_READ_COUNT);

   assign unused_addr_bits = ^{addr[18:16], addr[7:4]};

endmodule

// File: rtl/pin_controller.sv
// One output pin: constant low/high or free-running square wave with programmable phases.
// Optional PIN_CYCLE_COUNT_EN adds a completed-period counter readable with command 7.
module pin_controller
   import pin_pkg::*;
#(
   parameter logic [7:0] POSITION = 8'd0
) (
   input  logic             clk,
   input  logic             rst,
   pin_controller_if.slave  bus,
   output logic             pin_out,
   output logic             running
);

   logic       wr_acc, rd_acc;
   logic [3:0] cmd;

   cmd_decode #(.POSITION(POSITION)) u_dec (
      .addr   (bus.cmd_bus_addr),
      .en     (bus.cmd_bus_en),
      .wr     (bus.cmd_bus_wr),
      .rd     (bus.cmd_bus_rd),
      .wr_acc (wr_acc),
      .rd_acc (rd_acc),
      .cmd    (cmd)
   );

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] high_q, high_d;
   logic [15:0] low_q, low_d;
   logic        restart;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_LOW;
         cnt_q   <= 16'd0;
         high_q  <= 16'd1;
         low_q   <= 16'd1;
         pin_out <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         high_q  <= high_d;
         low_q   <= low_d;
         pin_out <= (state_d == ST_HIGH) || (state_d == ST_SQ_HI);
      end
   end

   // Wave advances with the times registered before this edge; an accepted
   // command then overrides state/counter for the same edge.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      high_d  = high_q;
      low_d   = low_q;
      restart = 1'b0;
      case (state_q)
         ST_SQ_HI: begin
            if (cnt_q >= eff_time(high_q)) begin
               state_d = ST_SQ_LO;
               cnt_d   = 16'd1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         ST_SQ_LO: begin
            if (cnt_q >= eff_time(low_q)) begin
               state_d = ST_SQ_HI;
               cnt_d   = 16'd1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: ;
      endcase
      if (wr_acc) begin
         case (cmd)
            CMD_CONST_LOW:  state_d = ST_LOW;
            CMD_CONST_HIGH: state_d = ST_HIGH;
            CMD_SET_HIGH:   high_d  = bus.cmd_bus_data;
            CMD_SET_LOW:    low_d   = bus.cmd_bus_data;
            CMD_START: begin
               state_d = ST_SQ_HI;
               cnt_d   = 16'd1;
               restart = 1'b1;
            end
            CMD_STOP: begin
               state_d = ST_LOW;
               cnt_d   = 16'd0;
               restart = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign running = (state_q == ST_SQ_HI) || (state_q == ST_SQ_LO);

`ifdef PIN_CYCLE_COUNT_EN
   logic [15:0] periods_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         periods_q    <= 16'd0;
         bus.rd_data  <= 16'd0;
         bus.rd_valid <= 1'b0;
      end else begin
         if (restart)
            periods_q <= 16'd0;
         else if (state_q == ST_SQ_LO && state_d == ST_SQ_HI)
            periods_q <= periods_q + 16'd1;
         bus.rd_valid <= rd_acc;
         bus.rd_data  <= rd_acc ? periods_q : 16'd0;
      end
   end
`else
   logic unused_rd;

   assign unused_rd    = rd_acc ^ restart;
   assign bus.rd_data  = 16'd0;
   assign bus.rd_valid = 1'b0;
`endif

endmodule

// File: tb/tb_pin_controller.sv
// Randomized bench for pin_controller against a level/age reference model.
module tb_pin_controller;
   localparam logic [7:0] POS = 8'd3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic pin_out, running;
   int   n_checks = 0;
   int   n_errors = 0;

   pin_controller_if bus();

   pin_controller #(.POSITION(POS)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .pin_out (pin_out),
      .running (running)
   );

   always #5 clk = ~clk;

   // Reference model: mode 0 const low, 1 const high, 2 square wave.
   int m_mode, m_age, m_hi, m_lo, m_cnt, e_rdd;
   bit m_lvl, e_rdv;

   function automatic int eff(input int t);
      return (t == 0) ? 1 : t;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_age = 0; m_hi = 1; m_lo = 1; m_cnt = 0;
      m_lvl = 1'b0; e_rdv = 1'b0; e_rdd = 0;
   endtask

   task automatic model_step(input bit en, input bit wr, input bit rd,
                             input logic [7:0] ctrl, input logic [3:0] cmd, input logic [15:0] data);
      bit acc, rdq;
      acc = en && wr && (ctrl == POS);
      rdq = en && rd && !wr && (ctrl == POS) && (cmd == 4'd7);
`ifdef PIN_CYCLE_COUNT_EN
      e_rdv = rdq;
      e_rdd = rdq ? m_cnt : 0;
`else
      e_rdv = 1'b0;
      e_rdd = 0;
`endif
      if (m_mode == 2) begin
         if (m_age >= eff(m_lvl ? m_hi : m_lo)) begin
            m_lvl = !m_lvl;
            m_age = 1;
            if (m_lvl) m_cnt = (m_cnt + 1) & 32'hFFFF;
         end else begin
            m_age++;
         end
      end
      if (acc) begin
         case (cmd)
            4'd0: m_mode = 0;
            4'd1: m_mode = 1;
            4'd2: m_hi = int'(data);
            4'd3: m_lo = int'(data);
            4'd4: begin m_mode = 2; m_lvl = 1'b1; m_age = 1; m_cnt = 0; end
            4'd5: begin m_mode = 0; m_cnt = 0; end
            default: ;
         endcase
      end
   endtask

   task automatic check_outputs();
      chk("pin_out", 32'(pin_out), 32'(m_mode == 1 || (m_mode == 2 && m_lvl)));
      chk("running", 32'(running), 32'(m_mode == 2));
      chk("rd_valid", 32'(bus.rd_valid), 32'(e_rdv));
      if (e_rdv) chk("rd_data", 32'(bus.rd_data), e_rdd);
`ifndef PIN_CYCLE_COUNT_EN
      chk("rd_data_tied", 32'(bus.rd_data), 32'd0);
`endif
   endtask

   // Check state after the previous edge, then drive and predict the next edge.
   task automatic cycle(input bit en, input bit wr, input bit rd,
                        input logic [7:0] ctrl, input logic [3:0] cmd, input logic [15:0] data);
      @(negedge clk);
      check_outputs();
      bus.cmd_bus_addr = {3'($urandom), ctrl, 4'($urandom), cmd};
      bus.cmd_bus_data = data;
      bus.cmd_bus_en   = en;
      bus.cmd_bus_wr   = wr;
      bus.cmd_bus_rd   = rd;
      model_step(en, wr, rd, ctrl, cmd, data);
   endtask

   task automatic wr_cmd(input logic [3:0] cmd, input logic [15:0] data);
      cycle(1'b1, 1'b1, 1'b0, POS, cmd, data);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, POS, 4'd15, 16'd0);
   endtask

   task automatic bus_idle();
      bus.cmd_bus_addr = 19'd0;
      bus.cmd_bus_data = 16'd0;
      bus.cmd_bus_en   = 1'b0;
      bus.cmd_bus_wr   = 1'b0;
      bus.cmd_bus_rd   = 1'b0;
   endtask

   initial begin
      bus_idle();
      model_reset();
      #12;
      check_outputs();
      @(negedge clk);
      rst = 1'b1;

      // Claimed vs foreign control byte.
      wr_cmd(4'd1, 16'd0);
      idle(2);
      wr_cmd(4'd0, 16'd0);
      cycle(1'b1, 1'b1, 1'b0, 8'd4, 4'd1, 16'd0);
      idle(2);

      // 3-high / 2-low wave, then stop.
      wr_cmd(4'd2, 16'd3);
      wr_cmd(4'd3, 16'd2);
      wr_cmd(4'd4, 16'd0);
      idle(12);
      wr_cmd(4'd5, 16'd0);
      idle(2);

      // Zero phase lengths toggle every cycle.
      wr_cmd(4'd2, 16'd0);
      wr_cmd(4'd3, 16'd0);
      wr_cmd(4'd4, 16'd0);
      idle(6);

      // Shrink high time mid-phase.
      wr_cmd(4'd2, 16'd10);
      wr_cmd(4'd3, 16'd1);
      wr_cmd(4'd4, 16'd0);
      idle(4);
      wr_cmd(4'd2, 16'd2);
      idle(10);

      // Async reset mid high phase.
      wr_cmd(4'd2, 16'd5);
      wr_cmd(4'd4, 16'd0);
      idle(2);
      @(negedge clk);
      check_outputs();
      rst = 1'b0;
      #1;
      chk("async_rst_pin", 32'(pin_out), 32'd0);
      chk("async_rst_run", 32'(running), 32'd0);
      model_reset();
      bus_idle();
      @(negedge clk);
      rst = 1'b1;
      wr_cmd(4'd4, 16'd0);
      idle(5);

`ifdef PIN_CYCLE_COUNT_EN
      wr_cmd(4'd2, 16'd1);
      wr_cmd(4'd3, 16'd1);
      wr_cmd(4'd4, 16'd0);
      idle(8);
      cycle(1'b1, 1'b0, 1'b1, POS, 4'd7, 16'd0);
      @(negedge clk);
      chk("count_rd_valid", 32'(bus.rd_valid), 32'd1);
      chk("count_rd_data", 32'(bus.rd_data), 32'd4);
      cycle(1'b1, 1'b1, 1'b1, POS, 4'd7, 16'd0);
      idle(2);
`else
      cycle(1'b1, 1'b0, 1'b1, POS, 4'd7, 16'd0);
      idle(2);
`endif

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         logic [7:0]  ctrl;
         logic [15:0] data;
         ctrl = ($urandom_range(0, 4) == 0) ? 8'($urandom) : POS;
         data = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(0, 20))
                                            : 16'($urandom_range(0, 5));
         cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
               1'($urandom_range(0, 2) == 0), ctrl, 4'($urandom_range(0, 8)), data);
      end
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
